// File: rtl/discrete_voice_scheduler_if.sv
// Step/result handshake between the voice scheduler (master) and the shared
// oscillator step engine (slave).
interface discrete_voice_scheduler_if;
    logic               step_valid;
    logic [2:0]         step_voice;
    logic               step_ready;
    logic               result_valid;
    logic [2:0]         result_voice;
    logic signed [15:0] result_sample;

    modport master (
        output step_valid, step_voice,
        input  step_ready, result_valid, result_voice, result_sample
    );

    modport slave (
        input  step_valid, step_voice,
        output step_ready, result_valid, result_voice, result_sample
    );
endinterface

// File: rtl/discrete_voice_scheduler.sv
// Time-shares one oscillator step engine across NUM_VOICES voices: one step
// request per enabled voice on each audio tick, then a saturated mix.
module discrete_voice_scheduler #(
    parameter int CLK_HZ      = 48000000,
    parameter int SAMPLE_RATE = 48000,
    parameter int NUM_VOICES  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_VOICES-1:0]        voice_enable,
    output logic                         audio_clk_en,
    discrete_voice_scheduler_if.master   step,
    output logic [NUM_VOICES*16-1:0]     voice_sample,
    output logic signed [15:0]           mix_sample,
    output logic                         mix_valid,
    output logic                         overrun,
    output logic                         proto_err
);
    localparam int DIV   = CLK_HZ / SAMPLE_RATE;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_MIX} state_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       div_cnt;
    logic [NUM_VOICES-1:0]  en_q;
    logic [2:0]             cur;
    logic signed [15:0]     samples [NUM_VOICES];

    logic                   tick;
    logic                   result_hit;
    logic                   next_found;
    logic [2:0]             first_idx;
    logic [2:0]             next_idx;
    logic signed [18:0]     mix_sum;
    logic signed [15:0]     mix_sat;

    assign tick         = (div_cnt == CNT_W'(DIV - 1));
    assign audio_clk_en = tick;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)     div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    assign result_hit = (state == S_WAIT) && step.result_valid && (step.result_voice == cur);

    assign step.step_valid = (state == S_ISSUE);
    assign step.step_voice = cur;

    // Descending scan: the last match written is the lowest qualifying index.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
        first_idx  = '0;
        next_idx   = '0;
        next_found = 1'b0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (voice_enable[i]) first_idx = 3'(i);
            if (en_q[i] && (3'(i) > cur)) begin
                next_found = 1'b1;
                next_idx   = 3'(i);
            end
        end
    end

    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (en_q[i]) mix_sum = mix_sum + $signed({{3{samples[i][15]}}, samples[i]});
        end
        if (mix_sum > 19'sd32767)       mix_sat = 16'sh7fff;
        else if (mix_sum < -19'sd32768) mix_sat = 16'sh8000;
        else                            mix_sat = mix_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (tick) state_nxt = (voice_enable == '0) ? S_MIX : S_ISSUE;
            S_ISSUE: if (step.step_ready) state_nxt = S_WAIT;
            S_WAIT:  if (result_hit) state_nxt = next_found ? S_ISSUE : S_MIX;
            S_MIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q       <= '0;
            cur        <= '0;
            mix_sample <= '0;
            mix_valid  <= 1'b0;
            overrun    <= 1'b0;
            proto_err  <= 1'b0;
            // NOTE: the sample store is a small register array, so it is reset explicitly; a RAM-style memory would not be.
            for (int i = 0; i < NUM_VOICES; i++) samples[i] <= '0;
        end else begin
            mix_valid <= 1'b0;
            if (tick && state != S_IDLE)           overrun   <= 1'b1;
            if (step.result_valid && !result_hit)  proto_err <= 1'b1;

            for (int i = 0; i < NUM_VOICES; i++) begin
                if (state == S_IDLE && tick && !voice_enable[i]) samples[i] <= '0;
                if (result_hit && cur == 3'(i))                  samples[i] <= step.result_sample;
            end

            case (state)
                S_IDLE: if (tick) begin
                    en_q <= voice_enable;
                    cur  <= first_idx;
                end
                S_WAIT: if (result_hit && next_found) cur <= next_idx;
                S_MIX: begin
                    mix_sample <= mix_sat;
                    mix_valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign voice_sample[16*g +: 16] = samples[g];
    end
endmodule

// File: tb/tb_discrete_voice_scheduler.sv
// Directed bench: divider timing, table-driven frames against a responsive
// engine model, then overrun, protocol-error and reset sequences.
module tb_discrete_voice_scheduler;
    localparam int NV = 4;

    typedef struct {
        logic [3:0]        en;
        logic [3:0][15:0]  resp;
        int                stall;
        int                exp_mix;
    } vec_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NV-1:0]       voice_enable = '0;
    logic                audio_clk_en;
    logic [NV*16-1:0]    voice_sample;
    logic signed [15:0]  mix_sample;
    logic                mix_valid;
    logic                overrun;
    logic                proto_err;

    discrete_voice_scheduler_if bus();

    discrete_voice_scheduler #(.CLK_HZ(48), .SAMPLE_RATE(4), .NUM_VOICES(NV)) dut (
        .clk          (clk),
        .reset        (reset),
        .voice_enable (voice_enable),
        .audio_clk_en (audio_clk_en),
        .step         (bus),
        .voice_sample (voice_sample),
        .mix_sample   (mix_sample),
        .mix_valid    (mix_valid),
        .overrun      (overrun),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    // Engine model: accepts on valid&ready, answers in the following cycle.
    logic [3:0][15:0]   resp;
    bit                 eng_respond = 1'b1;
    bit                 corrupt = 1'b0;
    bit                 stray_req = 1'b0;
    logic [2:0]         stray_voice = '0;
    logic signed [15:0] stray_sample = '0;
    int                 stall_left = 0;
    int                 stall_seen = 0;
    int                 hold_err = 0;
    int                 order_q[$];

    initial begin
        bit         pend = 1'b0;
        bit         prev_stalled = 1'b0;
        logic [2:0] pend_voice = '0;
        logic [2:0] prev_voice = '0;
        bus.step_ready    = 1'b1;
        bus.result_valid  = 1'b0;
        bus.result_voice  = '0;
        bus.result_sample = '0;
        forever begin
            @(negedge clk);
            bus.result_valid = 1'b0;
            if (reset) begin
                pend = 1'b0;
                prev_stalled = 1'b0;
            end else begin
                if (pend && eng_respond) begin
                    bus.result_valid  = 1'b1;
                    bus.result_voice  = corrupt ? 3'd2 : pend_voice;
                    bus.result_sample = resp[pend_voice[1:0]];
                end else if (stray_req) begin
                    bus.result_valid  = 1'b1;
                    bus.result_voice  = stray_voice;
                    bus.result_sample = stray_sample;
                    stray_req = 1'b0;
                end
                pend = 1'b0;
                if (prev_stalled && (!bus.step_valid || bus.step_voice != prev_voice)) hold_err++;
                if (bus.step_valid && stall_left > 0) begin
                    bus.step_ready = 1'b0;
                    stall_left--;
                    stall_seen++;
                end else begin
                    bus.step_ready = 1'b1;
                end
                prev_stalled = bus.step_valid && !bus.step_ready;
                prev_voice   = bus.step_voice;
                if (bus.step_valid && bus.step_ready) begin
                    pend = 1'b1;
                    pend_voice = bus.step_voice;
                    order_q.push_back(int'(bus.step_voice));
                end
            end
        end
    end

    // Returns with the current negedge inside a tick cycle, or ok=0.
    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (audio_clk_en) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) timeout("wait_tick");
    endtask

    task automatic wait_mix(input int limit, output int d, output bit ok);
        d = 0;
        ok = 1'b0;
        while (!mix_valid && d < limit) begin
            @(negedge clk);
            d++;
        end
        ok = mix_valid;
        if (!ok) timeout("wait_mix");
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        bit           ok;
        int           d;
        longint       exp_ord, act_ord;
        logic [63:0]  exp_vs;
        order_q.delete();
        voice_enable = v.en;
        resp         = v.resp;
        stall_left   = v.stall;
        stall_seen   = 0;
        hold_err     = 0;
        wait_tick(ok);
        if (!ok) return;
        @(negedge clk);
        check($sformatf("step_valid_after_tick[%0d]", idx), longint'(bus.step_valid), longint'(v.en != 0));
        voice_enable = ~v.en;
        d = 0;
        wait_mix(14, d, ok);
        if (!ok) return;
        d = d + 1;
        if (v.en == 0) check($sformatf("empty_latency[%0d]", idx), d, 2);
        exp_vs  = '0;
        exp_ord = 0;
        for (int i = 0; i < NV; i++) begin
            if (v.en[i]) begin
                exp_vs[16*i +: 16] = v.resp[i];
                exp_ord = exp_ord * 8 + i + 1;
            end
        end
        act_ord = 0;
        foreach (order_q[k]) act_ord = act_ord * 8 + order_q[k] + 1;
        check($sformatf("mix[%0d]", idx), longint'($signed(mix_sample)), longint'(v.exp_mix));
        check($sformatf("voice_sample[%0d]", idx), longint'(voice_sample), longint'(exp_vs));
        check($sformatf("step_order[%0d]", idx), act_ord, exp_ord);
        check($sformatf("stall_cycles[%0d]", idx), stall_seen, v.stall);
        check($sformatf("hold_stable[%0d]", idx), hold_err, 0);
        check($sformatf("flags[%0d]", idx), longint'({overrun, proto_err}), 0);
        @(negedge clk);
        check($sformatf("mix_pulse_width[%0d]", idx), longint'(mix_valid), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_voice_sample"}, longint'(voice_sample), 0);
        check({tag, "_mix_sample"},   longint'(mix_sample), 0);
        check({tag, "_strobes"},      longint'({audio_clk_en, bus.step_valid, mix_valid}), 0);
        check({tag, "_sticky"},       longint'({overrun, proto_err}), 0);
    endtask

    vec_t vecs[9];

    initial begin
        bit ok;
        int d;
        bit seen_mix;

        vecs[0] = '{4'b1011, {-16'sd50, 16'sd999, 16'sd200, 16'sd100}, 0, 250};
        vecs[1] = '{4'b1111, {16'sd20000, 16'sd20000, 16'sd20000, 16'sd20000}, 0, 32767};
        vecs[2] = '{4'b1111, {-16'sd20000, -16'sd20000, -16'sd20000, -16'sd20000}, 0, -32768};
        vecs[3] = '{4'b0000, {16'sd11, 16'sd22, 16'sd33, 16'sd44}, 0, 0};
        vecs[4] = '{4'b0011, {16'sd0, 16'sd0, -16'sd3, 16'sd7}, 5, 4};
        vecs[5] = '{4'b0100, {16'sd5, -16'sd1234, 16'sd5, 16'sd5}, 0, -1234};
        vecs[6] = '{4'b1001, {16'sd32767, 16'sd9, 16'sd9, 16'sd1}, 2, 32767};
        vecs[7] = '{4'b0110, {16'sd9, -16'sd32768, -16'sd1, 16'sd9}, 0, -32768};
        vecs[8] = '{4'b1111, {-16'sd4000, 16'sd3000, -16'sd2000, 16'sd1000}, 0, -2000};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_all_zero("reset");

        // Cycle c counts negedges since release; the tick lands on the 12th cycle.
        for (int c = 0; c <= 36; c++) begin
            if (c > 0) @(negedge clk);
            check($sformatf("audio_clk_en@%0d", c), longint'(audio_clk_en), longint'((c % 12) == 11));
        end

        foreach (vecs[i]) run_frame(vecs[i], i);

        // Engine stalls forever: the next tick must flag overrun with no mix.
        eng_respond  = 1'b0;
        voice_enable = 4'b0001;
        wait_tick(ok);
        seen_mix = 1'b0;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            if (mix_valid) seen_mix = 1'b1;
        end
        check("overrun_set", longint'(overrun), 1);
        check("overrun_no_mix", longint'(seen_mix), 0);
        check("overrun_no_reissue", longint'(bus.step_valid), 0);
        stray_voice  = 3'd0;
        stray_sample = 16'sd321;
        stray_req    = 1'b1;
        wait_mix(8, d, ok);
        if (ok) check("overrun_late_mix", longint'($signed(mix_sample)), 321);
        check("overrun_late_no_proto_err", longint'(proto_err), 0);
        eng_respond = 1'b1;

        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_all_zero("reset2");

        // Wrong voice index while cur=0 must be discarded and flagged.
        corrupt      = 1'b1;
        voice_enable = 4'b0001;
        resp         = {16'sd0, 16'sd0, 16'sd0, 16'sd555};
        wait_tick(ok);
        repeat (4) @(negedge clk);
        check("bad_voice_proto_err", longint'(proto_err), 1);
        check("bad_voice_discarded", longint'(voice_sample), 0);
        check("bad_voice_still_waiting", longint'(bus.step_valid), 0);
        corrupt = 1'b0;

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("reset1");

        run_frame('{4'b0001, {16'sd0, 16'sd0, 16'sd0, 16'sd42}, 0, 42}, 9);

        stray_voice  = 3'd1;
        stray_sample = 16'sd7;
        stray_req    = 1'b1;
        repeat (3) @(negedge clk);
        check("stray_idle_proto_err", longint'(proto_err), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end
endmodule
